// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and TX beat-count width for the UART command engine.
package sys_ctrl_pkg;

  localparam logic [7:0] OP_WR      = 8'hAA;
  localparam logic [7:0] OP_RD      = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  localparam int unsigned BEAT_W = 2;

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StOpA,
    StOpB,
    StAluFunc,
    StAluWait,
    StTxSend
  } state_t;

endpackage

// File: rtl/sys_ctrl_frame_timer.sv
// Inter-byte frame timer: counts enabled idle cycles and flags the terminal count.
module sys_ctrl_frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = en && (cnt == LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr || !en || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sys_ctrl_cmd_engine.sv
// UART command engine: decodes RF write/read and ALU frames and returns results to UART TX.
module sys_ctrl_cmd_engine
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUNC_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Rx_valid,
  input  logic [DATA_WIDTH-1:0]   RX_out,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    Tx_busy,
  output logic [ADDR_WIDTH-1:0]   Addr,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [DATA_WIDTH-1:0]   Wr_D,
  output logic                    ALU_EN,
  output logic [FUNC_WIDTH-1:0]   Func,
  output logic                    Gate_En,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    Cmd_err,
  output logic                    Timeout_err
);

  state_t                  state;
  logic [2*DATA_WIDTH-1:0] tx_buf;
  logic [BEAT_W-1:0]       beats;
  logic                    byte_ok;
  logic                    tmr_clr;
  logic                    tmr_en;
  logic                    expired;

  // Bytes arriving while waiting on RF/ALU or sending are dropped and do not refresh the timer.
  assign byte_ok = Rx_valid && !(state inside {StRdWait, StAluWait, StTxSend});
  assign tmr_clr = byte_ok || (state == StRdWait && RdData_Valid) ||
                   (state == StAluWait && ALU_OUT_VLD);
  assign tmr_en  = !(state inside {StIdle, StTxSend});

  sys_ctrl_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= StIdle;
      Addr        <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      Wr_D        <= '0;
      ALU_EN      <= 1'b0;
      Func        <= '0;
      Gate_En     <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      Cmd_err     <= 1'b0;
      Timeout_err <= 1'b0;
      tx_buf      <= '0;
      beats       <= '0;
    end else begin
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      ALU_EN      <= 1'b0;
      Cmd_err     <= 1'b0;
      Timeout_err <= 1'b0;
      if (expired && !tmr_clr) begin
        state       <= StIdle;
        Timeout_err <= 1'b1;
        Gate_En     <= 1'b0;
      end else begin
        case (state)
          StIdle: begin
            if (Rx_valid) begin
              if (RX_out == DATA_WIDTH'(OP_WR)) begin
                state <= StWrAddr;
              end else if (RX_out == DATA_WIDTH'(OP_RD)) begin
                state <= StRdAddr;
              end else if (RX_out == DATA_WIDTH'(OP_ALU_OP)) begin
                state <= StOpA;
              end else if (RX_out == DATA_WIDTH'(OP_ALU_NOP)) begin
                state   <= StAluFunc;
                Gate_En <= 1'b1;
              end else begin
                Cmd_err <= 1'b1;
              end
            end
          end
          StWrAddr: if (Rx_valid) begin
            Addr  <= RX_out[ADDR_WIDTH-1:0];
            state <= StWrData;
          end
          StWrData: if (Rx_valid) begin
            WrEn  <= 1'b1;
            Wr_D  <= RX_out;
            state <= StIdle;
          end
          StRdAddr: if (Rx_valid) begin
            RdEn  <= 1'b1;
            Addr  <= RX_out[ADDR_WIDTH-1:0];
            state <= StRdWait;
          end
          StRdWait: if (RdData_Valid) begin
            tx_buf    <= {{DATA_WIDTH{1'b0}}, RdData};
            TX_P_DATA <= RdData;
            TX_D_VLD  <= 1'b1;
            beats     <= BEAT_W'(1);
            state     <= StTxSend;
          end
          StOpA: if (Rx_valid) begin
            WrEn  <= 1'b1;
            Addr  <= ADDR_WIDTH'(0);
            Wr_D  <= RX_out;
            state <= StOpB;
          end
          StOpB: if (Rx_valid) begin
            WrEn    <= 1'b1;
            Addr    <= ADDR_WIDTH'(1);
            Wr_D    <= RX_out;
            Gate_En <= 1'b1;
            state   <= StAluFunc;
          end
          StAluFunc: if (Rx_valid) begin
            ALU_EN <= 1'b1;
            Func   <= RX_out[FUNC_WIDTH-1:0];
            state  <= StAluWait;
          end
          StAluWait: if (ALU_OUT_VLD) begin
            tx_buf    <= ALU_OUT;
            TX_P_DATA <= ALU_OUT[DATA_WIDTH-1:0];
            TX_D_VLD  <= 1'b1;
            beats     <= BEAT_W'(2);
            Gate_En   <= 1'b0;
            state     <= StTxSend;
          end
          StTxSend: begin
            // First beat is presented on capture; later beats wait for Tx_busy to clear.
            if (TX_D_VLD) begin
              if (!Tx_busy) begin
                TX_D_VLD <= 1'b0;
                tx_buf   <= tx_buf >> DATA_WIDTH;
                beats    <= beats - BEAT_W'(1);
                if (beats == BEAT_W'(1)) state <= StIdle;
              end
            end else if (!Tx_busy) begin
              TX_D_VLD  <= 1'b1;
              TX_P_DATA <= tx_buf[DATA_WIDTH-1:0];
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_ctrl_cmd_engine.sv
// Scoreboard bench for sys_ctrl_cmd_engine: directed frames, queued expectations, negedge monitor.
module tb_sys_ctrl_cmd_engine;
  import sys_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int TO = 32;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            Rx_valid = 1'b0;
  logic [DW-1:0]   RX_out = '0;
  logic [DW-1:0]   RdData = '0;
  logic            RdData_Valid = 1'b0;
  logic [2*DW-1:0] ALU_OUT = '0;
  logic            ALU_OUT_VLD = 1'b0;
  logic            Tx_busy = 1'b0;
  logic [AW-1:0]   Addr;
  logic            WrEn;
  logic            RdEn;
  logic [DW-1:0]   Wr_D;
  logic            ALU_EN;
  logic [FW-1:0]   Func;
  logic            Gate_En;
  logic [DW-1:0]   TX_P_DATA;
  logic            TX_D_VLD;
  logic            Cmd_err;
  logic            Timeout_err;

  sys_ctrl_cmd_engine #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .FUNC_WIDTH    (FW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Rx_valid    (Rx_valid),
    .RX_out      (RX_out),
    .RdData      (RdData),
    .RdData_Valid(RdData_Valid),
    .ALU_OUT     (ALU_OUT),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .Tx_busy     (Tx_busy),
    .Addr        (Addr),
    .WrEn        (WrEn),
    .RdEn        (RdEn),
    .Wr_D        (Wr_D),
    .ALU_EN      (ALU_EN),
    .Func        (Func),
    .Gate_En     (Gate_En),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD),
    .Cmd_err     (Cmd_err),
    .Timeout_err (Timeout_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+DW-1:0] wr_q[$];
  logic [AW-1:0]    rd_q[$];
  logic [FW-1:0]    alu_q[$];
  logic [DW-1:0]    tx_q[$];
  bit               cmd_q[$];
  bit               to_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event, value 0x%0h, expected none", name, act);
  endtask

  function automatic logic [31:0] all_outs();
    return {1'b0, Addr, WrEn, RdEn, Wr_D, ALU_EN, Func, Gate_En, TX_P_DATA, TX_D_VLD,
            Cmd_err, Timeout_err};
  endfunction

  // Monitor: every strobe or TX transfer pops the matching scoreboard queue.
  logic          gate_prev = 1'b0;
  logic          vld_prev  = 1'b0;
  logic          xfer_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;

  always @(negedge CLK) begin
    logic xfer;
    xfer = TX_D_VLD && !Tx_busy;
    if (!RST) begin
      gate_prev = 1'b0;
      vld_prev  = 1'b0;
      xfer_prev = 1'b0;
    end else begin
      if (WrEn || RdEn || ALU_EN)
        check("strobe_exclusive", 32'(int'(WrEn) + int'(RdEn) + int'(ALU_EN)), 32'd1);
      if (WrEn) begin
        if (wr_q.size() == 0) unexpected("wr", {20'd0, Addr, Wr_D});
        else check("wr", {20'd0, Addr, Wr_D}, {20'd0, wr_q.pop_front()});
      end
      if (RdEn) begin
        if (rd_q.size() == 0) unexpected("rd", {28'd0, Addr});
        else check("rd_addr", {28'd0, Addr}, {28'd0, rd_q.pop_front()});
      end
      if (ALU_EN) begin
        if (alu_q.size() == 0) unexpected("alu", {28'd0, Func});
        else check("alu_func", {28'd0, Func}, {28'd0, alu_q.pop_front()});
        check("gate_before_alu_en", {30'd0, gate_prev, Gate_En}, 32'd3);
      end
      if (Cmd_err) begin
        if (cmd_q.size() == 0) unexpected("cmd_err", 32'd1);
        else void'(cmd_q.pop_front());
      end
      if (Timeout_err) begin
        if (to_q.size() == 0) unexpected("timeout_err", 32'd1);
        else void'(to_q.pop_front());
      end
      if (vld_prev && !xfer_prev && TX_D_VLD)
        check("tx_hold", {24'd0, TX_P_DATA}, {24'd0, data_prev});
      if (xfer) begin
        if (tx_q.size() == 0) unexpected("tx", {24'd0, TX_P_DATA});
        else check("tx_beat", {24'd0, TX_P_DATA}, {24'd0, tx_q.pop_front()});
      end
      gate_prev = Gate_En;
      vld_prev  = TX_D_VLD;
      xfer_prev = xfer;
      data_prev = TX_P_DATA;
    end
  end

  // Tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [DW-1:0] b);
    Rx_valid = 1'b1;
    RX_out   = b;
    @(posedge CLK); #1;
    Rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_rd_respond(input logic [DW-1:0] d, input bit stray);
    int k = 0;
    while (!RdEn && k < 50) begin @(negedge CLK); k++; end
    if (k >= 50) unexpected("rd_wait_timeout", 32'(k));
    @(posedge CLK); #1;
    if (stray) send_byte(8'h77);
    RdData       = d;
    RdData_Valid = 1'b1;
    @(posedge CLK); #1;
    RdData_Valid = 1'b0;
  endtask

  task automatic wait_alu_respond(input logic [2*DW-1:0] r);
    int k = 0;
    while (!ALU_EN && k < 50) begin @(negedge CLK); k++; end
    if (k >= 50) unexpected("alu_wait_timeout", 32'(k));
    @(posedge CLK); #1;
    ALU_OUT     = r;
    ALU_OUT_VLD = 1'b1;
    @(posedge CLK); #1;
    ALU_OUT_VLD = 1'b0;
  endtask

  task automatic drain_tx();
    int k = 0;
    while (tx_q.size() != 0 && k < 200) begin @(posedge CLK); k++; end
    if (k >= 200) unexpected("tx_drain_timeout", 32'(tx_q.size()));
    #1;
  endtask

  initial begin
    int k;
    #2 RST = 1'b0;
    idle(2);
    check("reset_outputs", all_outs(), 32'd0);
    RST = 1'b1;
    idle(1);

    // Register write
    wr_q.push_back({4'h5, 8'h3C});
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    idle(3);

    // Register read, with a stray byte and an unsolicited ALU strobe that must be ignored
    rd_q.push_back(4'h5);
    tx_q.push_back(8'h3C);
    send_byte(8'hBB); send_byte(8'h05);
    wait_rd_respond(8'h3C, 1'b1);
    drain_tx();
    ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
    idle(1);
    ALU_OUT_VLD = 1'b0;
    idle(2);

    // ALU with operands
    wr_q.push_back({4'h0, 8'h12});
    wr_q.push_back({4'h1, 8'h34});
    alu_q.push_back(4'h1);
    tx_q.push_back(8'h46);
    tx_q.push_back(8'h00);
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h01);
    wait_alu_respond(16'h0046);
    drain_tx();
    idle(2);

    // ALU without operands, TX busy holds the first beat
    Tx_busy = 1'b1;
    alu_q.push_back(4'h2);
    tx_q.push_back(8'hCD);
    tx_q.push_back(8'hAB);
    send_byte(8'hDD); send_byte(8'h02);
    wait_alu_respond(16'hABCD);
    idle(20);
    check("busy_vld_held", {31'd0, TX_D_VLD}, 32'd1);
    check("busy_data_held", {24'd0, TX_P_DATA}, 32'hCD);
    Tx_busy = 1'b0;
    drain_tx();
    idle(2);

    // Frame timeout: fires TO edges after the opcode is accepted
    to_q.push_back(1'b1);
    send_byte(8'hAA);
    k = 0;
    while (!Timeout_err && k < TO + 10) begin @(negedge CLK); k++; end
    check("timeout_latency", 32'(k), 32'(TO + 1));
    @(posedge CLK); #1;
    wr_q.push_back({4'h1, 8'hFF});
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    idle(3);

    // Unknown opcode
    cmd_q.push_back(1'b1);
    send_byte(8'h55);
    idle(3);

    // Reset in the middle of OPB
    wr_q.push_back({4'h0, 8'h12});
    send_byte(8'hCC); send_byte(8'h12);
    idle(1);
    RST = 1'b0;
    @(negedge CLK);
    check("midframe_reset_outputs", all_outs(), 32'd0);
    check("midframe_reset_state", {28'd0, dut.state}, {28'd0, StIdle});
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(1);
    wr_q.push_back({4'h3, 8'h5A});
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h5A);
    idle(5);

    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("alu_q_empty", 32'(alu_q.size()), 32'd0);
    check("tx_q_empty", 32'(tx_q.size()), 32'd0);
    check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
    check("to_q_empty", 32'(to_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
